// File: rtl/blockmix_sched_pkg.sv
// blockmix_sched_pkg
// Shared definitions for the blockmix scheduler slice.
//   DATA_W_DEF : default blockmix block width in bits
//   CNT_W      : width of the per-job timeout counter
//   state_t    : scheduler FSM state encoding (IDLE, RUN, RESP)
package blockmix_sched_pkg;

  localparam int DATA_W_DEF = 1024;
  localparam int CNT_W      = 16;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/blockmix_scheduler_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick among NUM_REQ requesters.
// Ports:
//   req        in   NUM_REQ  request bits
//   last_grant in   IDX_W    index granted last time; search starts one above it
//   grant      out  IDX_W    winning index (0 when nothing is requested)
//   any        out  1        at least one request bit is set
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               any
);

  logic [IDX_W-1:0] idx;

  // Walk the requesters starting just after the previous winner and wrap
  // around; the last slot visited is the previous winner itself, so a lone
  // requester can be granted repeatedly.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/blockmix_scheduler.sv
// blockmix_scheduler
// Shares one blockmix core between NUM_REQ requesters, one job at a time.
// A round-robin winner is accepted in IDLE, its block is handed to the core
// while core_init is held high (RUN), and the result (or a timeout abort)
// is returned to the owner as a one-cycle pulse (RESP).
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   req_valid     in   NUM_REQ         per-requester job request
//   req_data      in   NUM_REQ*DATA_W  per-requester input blocks
//   req_ready     out  NUM_REQ         one-hot accept pulse
//   rsp_valid     out  NUM_REQ         one-hot result pulse to the owner
//   rsp_data      out  DATA_W          result block
//   rsp_err       out  1               job aborted by timeout
//   core_init     out  1               init/start of the shared core
//   core_in       out  DATA_W          registered block fed to the core
//   core_out      in   DATA_W          core result
//   core_valid    in   1               core result valid
//   busy          out  1               scheduler not idle
module blockmix_scheduler
  import blockmix_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      core_init,
  output logic [DATA_W-1:0]         core_in,
  input  logic [DATA_W-1:0]         core_out,
  input  logic                      core_valid,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT_LSB  = NUM_REQ'(1);

  state_t             state;
  logic [IDX_W-1:0]   grant_id;
  logic [IDX_W-1:0]   last_grant;
  logic [CNT_W-1:0]   counter;
  logic [IDX_W-1:0]   win;
  logic               win_any;
  logic [DATA_W-1:0]  sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (win),
    .any        (win_any)
  );

  // Select the winning requester's input block for capture into core_in.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDX_W'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Job sequencing. req_ready and rsp_valid default to zero every cycle so
  // they can only ever be single-cycle pulses. core_valid is looked at only
  // in RUN, and it takes priority over the timeout on the final RUN cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      core_init  <= 1'b0;
      core_in    <= '0;
      counter    <= '0;
      grant_id   <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            state      <= ST_RUN;
            grant_id   <= win;
            last_grant <= win;
            core_in    <= sel_data;
            req_ready  <= ONE_HOT_LSB << win;
            counter    <= '0;
            core_init  <= 1'b1;
          end
        end
        ST_RUN: begin
          counter <= counter + 1'b1;
          if (core_valid) begin
            state     <= ST_RESP;
            rsp_data  <= core_out;
            rsp_err   <= 1'b0;
            rsp_valid <= ONE_HOT_LSB << grant_id;
            core_init <= 1'b0;
          end else if (counter == TIMEOUT_LAST) begin
            state     <= ST_RESP;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= ONE_HOT_LSB << grant_id;
            core_init <= 1'b0;
          end
        end
        ST_RESP: begin
          // Result is only meaningful during the pulse, so clear it after.
          state    <= ST_IDLE;
          rsp_data <= '0;
          rsp_err  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          core_init <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
